// File: rtl/light_grid_pkg.sv
// Shared light-grid types: coordinates, opcodes, instruction word and row command layouts.
// Used by the instruction buffer, the grid instruction sequencer and the row-update engine.
// No logic; the only helper is a grid-bounds check on one coordinate.
package light_grid_pkg;

  localparam int COORD_WIDTH       = 10;
  localparam int GRID_SIZE         = 1000;
  localparam int INSTRUCTION_WIDTH = 4 + 4 * COORD_WIDTH;

  typedef logic [COORD_WIDTH-1:0] coord_t;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_ON     = 2'b01,
    OP_OFF    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  // Bit order matches the buffer's word: {last, valid, op, x0, y0, x1, y1}.
  typedef struct packed {
    logic   last;
    logic   valid;
    op_t    op;
    coord_t x0;
    coord_t y0;
    coord_t x1;
    coord_t y1;
  } instr_t;

  typedef struct packed {
    op_t    op;
    coord_t row;
    coord_t x0;
    coord_t x1;
  } cmd_t;

  function automatic logic coord_in_grid(input coord_t c);
    return int'(c) < GRID_SIZE;
  endfunction

endpackage

// File: rtl/grid_instruction_sequencer.sv
// Purpose: expands each light-grid rectangle instruction into one row command per Y coordinate.
// Latency: instruction handshake to first cmd_valid is 2 cycles; then one row per cycle.
// Backpressure: cmd_ready low holds the current command stable; instr_ready only high in FETCH.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   instr_valid/ready/data/last  read side of the instruction buffer
//   cmd_valid/ready, cmd_op, cmd_row, cmd_x0, cmd_x1   row command to the row-update engine
//   engine_busy                row engine still has commands in flight
//   done, error                sticky completion / malformed-instruction flags
//
// Build option: define GRID_SEQ_NORMALIZE_EN to swap reversed X/Y ranges instead of
// rejecting them as malformed.
module grid_instruction_sequencer
  import light_grid_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  input  logic [INSTRUCTION_WIDTH-1:0] instr_data,
  input  logic                         instr_last,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [1:0]                   cmd_op,
  output logic [COORD_WIDTH-1:0]       cmd_row,
  output logic [COORD_WIDTH-1:0]       cmd_x0,
  output logic [COORD_WIDTH-1:0]       cmd_x1,
  input  logic                         engine_busy,
  output logic                         done,
  output logic                         error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CHECK,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  instr_t instr_w;
  op_t    op_q;
  coord_t x0_q, y0_q, x1_q, y1_q;
  coord_t row_q;
  logic   last_q;
  logic   error_q;

  logic bad_op, bad_coord, rev_x, rev_y, malformed, last_row;

  assign instr_w = instr_data;

  // The buffer already gates the word with its own valid bit, and the last flag
  // arrives on its dedicated port, so both embedded bits are deliberately dropped.
  logic unused_word_bits;
  assign unused_word_bits = ^{instr_w.last, instr_w.valid};

  assign bad_op    = (op_q == OP_NOP);
  assign bad_coord = !coord_in_grid(x0_q) || !coord_in_grid(y0_q) ||
                     !coord_in_grid(x1_q) || !coord_in_grid(y1_q);
  assign rev_x     = (x0_q > x1_q);
  assign rev_y     = (y0_q > y1_q);

`ifdef GRID_SEQ_NORMALIZE_EN
  assign malformed = bad_op || bad_coord;
`else
  assign malformed = bad_op || bad_coord || rev_x || rev_y;
`endif

  // y1 < GRID_SIZE is guaranteed before ISSUE, so the equality stop can never be skipped.
  assign last_row = (row_q == y1_q);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (instr_valid) state_nxt = S_CHECK;
      S_CHECK: begin
        if (malformed) state_nxt = last_q ? S_DRAIN : S_FETCH;
        else           state_nxt = S_ISSUE;
      end
      S_ISSUE: if (cmd_ready && last_row) state_nxt = last_q ? S_DRAIN : S_FETCH;
      S_DRAIN: if (!engine_busy) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= OP_NOP;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      row_q   <= '0;
      last_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_FETCH: begin
          if (instr_valid) begin
            op_q   <= instr_w.op;
            x0_q   <= instr_w.x0;
            y0_q   <= instr_w.y0;
            x1_q   <= instr_w.x1;
            y1_q   <= instr_w.y1;
            last_q <= instr_last;
          end
        end
        S_CHECK: begin
          if (malformed) begin
            error_q <= 1'b1;
          end else begin
`ifdef GRID_SEQ_NORMALIZE_EN
            // Store ranges low..high so ISSUE always counts upward to y1_q.
            x0_q  <= rev_x ? x1_q : x0_q;
            x1_q  <= rev_x ? x0_q : x1_q;
            y0_q  <= rev_y ? y1_q : y0_q;
            y1_q  <= rev_y ? y0_q : y1_q;
            row_q <= rev_y ? y1_q : y0_q;
`else
            row_q <= y0_q;
`endif
          end
        end
        S_ISSUE: begin
          if (cmd_ready && !last_row) row_q <= row_q + coord_t'(1);
        end
        default: ;
      endcase
    end
  end

  assign instr_ready = (state == S_FETCH);
  assign cmd_valid   = (state == S_ISSUE);
  assign cmd_op      = op_q;
  assign cmd_row     = row_q;
  assign cmd_x0      = x0_q;
  assign cmd_x1      = x1_q;
  assign done        = (state == S_DONE);
  assign error       = error_q;

endmodule

// File: tb/tb_grid_instruction_sequencer.sv
module tb_grid_instruction_sequencer;
  import light_grid_pkg::*;

  logic                         clk = 1'b0;
  logic                         reset = 1'b1;
  logic                         instr_valid = 1'b0;
  logic                         instr_ready;
  logic [INSTRUCTION_WIDTH-1:0] instr_data = '0;
  logic                         instr_last = 1'b0;
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [1:0]                   cmd_op;
  logic [COORD_WIDTH-1:0]       cmd_row, cmd_x0, cmd_x1;
  logic                         engine_busy;
  logic                         done, error;

  grid_instruction_sequencer dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_last(instr_last),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_x0(cmd_x0), .cmd_x1(cmd_x1),
    .engine_busy(engine_busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // cmd_ready / engine_busy: 0 always-ready/idle, 1 toggle/random, 2 random, 3 manual
  int   rdy_mode = 0;
  int   busy_mode = 0;
  logic rdy_auto = 1'b1, rdy_manual = 1'b1;
  logic busy_auto = 1'b0, busy_manual = 1'b0;

  assign cmd_ready   = (rdy_mode == 3) ? rdy_manual : rdy_auto;
  assign engine_busy = (busy_mode == 2) ? busy_manual : busy_auto;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       rdy_auto = 1'b1;
      1:       rdy_auto = ~rdy_auto;
      default: rdy_auto = ($urandom_range(0, 2) != 0);
    endcase
    busy_auto = (busy_mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
  end

  // Monitor: collects accepted commands and counts protocol violations.
  cmd_t got[$];
  int   stab_viol = 0;
  int   overlap = 0;
  logic stalled_prev = 1'b0;
  cmd_t held;
  cmd_t cur;

  always @(negedge clk) begin
    cur = '{op: op_t'(cmd_op), row: cmd_row, x0: cmd_x0, x1: cmd_x1};
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) got.push_back(cur);
      if (stalled_prev && (!cmd_valid || cur != held)) stab_viol++;
      if (instr_ready && cmd_valid) overlap++;
      stalled_prev = cmd_valid && !cmd_ready;
      held = cur;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    int x0, y0, x1, y1;
  } ins_t;

  ins_t prog[$];
  cmd_t exp_q[$];

  // Reference: a rectangle is legal when op is non-zero and every coordinate lies on the grid;
  // it yields one command per row from low Y to high Y covering low X..high X.
  task automatic model(output int exp_err);
    exp_err = 0;
    exp_q.delete();
    foreach (prog[i]) begin
      int  xl, xh, yl, yh;
      bit  bad;
      bad = (prog[i].op == 2'b00) || prog[i].x0 >= GRID_SIZE || prog[i].x1 >= GRID_SIZE ||
            prog[i].y0 >= GRID_SIZE || prog[i].y1 >= GRID_SIZE;
`ifndef GRID_SEQ_NORMALIZE_EN
      if (prog[i].x0 > prog[i].x1 || prog[i].y0 > prog[i].y1) bad = 1;
`endif
      xl = (prog[i].x0 < prog[i].x1) ? prog[i].x0 : prog[i].x1;
      xh = (prog[i].x0 < prog[i].x1) ? prog[i].x1 : prog[i].x0;
      yl = (prog[i].y0 < prog[i].y1) ? prog[i].y0 : prog[i].y1;
      yh = (prog[i].y0 < prog[i].y1) ? prog[i].y1 : prog[i].y0;
      if (bad) exp_err = 1;
      else for (int y = yl; y <= yh; y++)
        exp_q.push_back('{op: op_t'(prog[i].op), row: coord_t'(y), x0: coord_t'(xl), x1: coord_t'(xh)});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input ins_t p, input logic last, output bit ok);
    instr_data  = {last, 1'b1, p.op, coord_t'(p.x0), coord_t'(p.y0), coord_t'(p.x1), coord_t'(p.y1)};
    instr_last  = last;
    instr_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (instr_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound && !ok; i++) begin
      @(negedge clk);
      if (done) ok = 1;
    end
  endtask

  task automatic run_prog(input string name, output int base);
    bit ok;
    int exp_err, st0, ov0, bad_idx;
    do_reset();
    base = got.size();
    st0 = stab_viol;
    ov0 = overlap;
    model(exp_err);
    foreach (prog[i]) begin
      send(prog[i], (i == prog.size() - 1), ok);
      chk({name, "_accept"}, int'(ok), 1);
      if (!ok) return;
    end
    wait_done(20000, ok);
    chk({name, "_done"}, int'(ok), 1);
    chk({name, "_error"}, int'(error), exp_err);
    chk({name, "_ncmd"}, got.size() - base, exp_q.size());
    bad_idx = -1;
    foreach (exp_q[i])
      if (bad_idx < 0 && (base + i >= got.size() || got[base + i] != exp_q[i])) bad_idx = i;
    chk({name, "_cmd_first_bad_idx"}, bad_idx, -1);
    chk({name, "_stability"}, stab_viol - st0, 0);
    chk({name, "_ready_overlap"}, overlap - ov0, 0);
  endtask

  typedef struct {
    logic [1:0] op;
    int x0, y0, x1, y1;
    int exp_err, exp_n, exp_first;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int   base;
    bit   ok;
    ins_t p;

    vecs[0] = '{2'b11, 0, 0, 999, 0, 0, 1, 0};
    vecs[1] = '{2'b01, 499, 499, 500, 500, 0, 2, 499};
    vecs[2] = '{2'b00, 1, 1, 2, 2, 1, 0, -1};
    vecs[3] = '{2'b10, 0, 0, 0, 0, 0, 1, 0};
`ifdef GRID_SEQ_NORMALIZE_EN
    vecs[4] = '{2'b10, 5, 9, 2, 3, 0, 7, 3};
`else
    vecs[4] = '{2'b10, 5, 9, 2, 3, 1, 0, -1};
`endif
    vecs[5] = '{2'b01, 0, 0, 1000, 0, 1, 0, -1};
    vecs[6] = '{2'b01, 999, 999, 999, 999, 0, 1, 999};
    vecs[7] = '{2'b11, 3, 0, 3, 999, 0, 1000, 0};
    vecs[8] = '{2'b01, 0, 5, 0, 1023, 1, 0, -1};

    // Reset values, sampled while the FSM still sits in IDLE.
    do_reset();
    @(negedge clk);
    chk("rst_instr_ready", int'(instr_ready), 0);
    chk("rst_cmd_valid", int'(cmd_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_cmd_fields", int'({cmd_op, cmd_row, cmd_x0, cmd_x1}), 0);
    @(negedge clk);
    chk("rst_fetch_ready", int'(instr_ready), 1);

    // Table-driven single-instruction programs.
    rdy_mode = 0;
    busy_mode = 0;
    foreach (vecs[i]) begin
      string nm;
      int    act_first;
      nm = $sformatf("vec%0d", i);
      prog.delete();
      prog.push_back('{vecs[i].op, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1});
      run_prog(nm, base);
      chk({nm, "_tbl_err"}, int'(error), vecs[i].exp_err);
      chk({nm, "_tbl_n"}, got.size() - base, vecs[i].exp_n);
      act_first = (got.size() > base) ? int'(got[base].row) : -1;
      chk({nm, "_tbl_first_row"}, act_first, vecs[i].exp_first);
    end

    // Done follows engine_busy falling by one cycle.
    do_reset();
    base = got.size();
    busy_mode = 2;
    busy_manual = 1'b1;
    p = '{2'b11, 0, 0, 999, 0};
    send(p, 1'b1, ok);
    chk("t1_accept", int'(ok), 1);
    for (int i = 0; i < 50 && got.size() < base + 1; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t1_done_while_busy", int'(done), 0);
    chk("t1_ncmd", got.size() - base, 1);
    if (got.size() > base)
      chk("t1_cmd", int'(got[base] == '{op: OP_TOGGLE, row: 10'd0, x0: 10'd0, x1: 10'd999}), 1);
    else
      chk("t1_cmd_missing", got.size() - base, 1);
    @(posedge clk);
    #1 busy_manual = 1'b0;
    @(negedge clk);
    chk("t1_done_same_cycle", int'(done), 0);
    @(negedge clk);
    chk("t1_done_next_cycle", int'(done), 1);
    busy_mode = 0;

    // Two-cycle latency and back-to-back rows.
    do_reset();
    p = '{2'b01, 499, 499, 500, 500};
    send(p, 1'b1, ok);
    chk("t2_accept", int'(ok), 1);
    @(negedge clk);
    chk("t2_lat1_valid", int'(cmd_valid), 0);
    chk("t2_lat1_ready", int'(instr_ready), 0);
    @(negedge clk);
    chk("t2_row0_valid", int'(cmd_valid), 1);
    chk("t2_row0", int'(cmd_row), 499);
    chk("t2_row0_ready", int'(instr_ready), 0);
    @(negedge clk);
    chk("t2_row1_valid", int'(cmd_valid), 1);
    chk("t2_row1", int'(cmd_row), 500);
    chk("t2_row1_x", int'({cmd_x0, cmd_x1}), int'({10'd499, 10'd500}));
    @(negedge clk);
    chk("t2_after_valid", int'(cmd_valid), 0);

    // Same rectangle with cmd_ready toggling every cycle.
    rdy_mode = 1;
    prog.delete();
    prog.push_back('{2'b01, 499, 499, 500, 500});
    run_prog("t3", base);
    rdy_mode = 0;

    // Malformed instruction followed by a valid last one.
    prog.delete();
    prog.push_back('{2'b00, 0, 0, 0, 0});
    prog.push_back('{2'b10, 0, 0, 0, 0});
    run_prog("t4", base);

    // Reset in the middle of a full-height rectangle.
    do_reset();
    p = '{2'b11, 0, 0, 999, 999};
    send(p, 1'b1, ok);
    chk("t6_accept", int'(ok), 1);
    ok = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (cmd_valid && cmd_row == 10'd400) ok = 1;
    end
    chk("t6_reached_row400", int'(ok), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_cmd_valid", int'(cmd_valid), 0);
    chk("t6_rst_done", int'(done), 0);
    chk("t6_rst_error", int'(error), 0);
    chk("t6_rst_row", int'(cmd_row), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_idle_ready", int'(instr_ready), 0);
    @(negedge clk);
    chk("t6_fetch_ready", int'(instr_ready), 1);
    chk("t6_no_cmd", int'(cmd_valid), 0);

    // Randomised programs against the reference model.
    rdy_mode = 2;
    busy_mode = 1;
    for (int t = 0; t < 30; t++) begin
      int n;
      prog.delete();
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        ins_t r;
        r.op = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
        r.x0 = $urandom_range(0, 1000);
        r.x1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1000) : r.x0 + $urandom_range(0, 20);
        if (r.x1 > 1003) r.x1 = 1003;
        r.y0 = $urandom_range(0, 1002);
        if ($urandom_range(0, 3) == 0) begin
          r.y1 = r.y0 - $urandom_range(0, 4);
          if (r.y1 < 0) r.y1 = 0;
        end else begin
          r.y1 = r.y0 + $urandom_range(0, 6);
        end
        prog.push_back(r);
      end
      run_prog($sformatf("rnd%0d", t), base);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
